// File: rtl/bp_fe_realigner.sv
// Fetch-block realigner: buffers 16-bit parcels from fetch blocks and presents
// whole 16/32-bit instructions with their PCs at the head of a circular buffer.
module bp_fe_realigner #(
    parameter int vaddr_width_p   = 39,
    parameter int fetch_parcels_p = 4,
    parameter int buf_els_p       = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 flush_i,
    input  logic                                 fetch_v_i,
    output logic                                 fetch_ready_and_o,
    input  logic [vaddr_width_p-1:0]             fetch_pc_i,
    input  logic [16*fetch_parcels_p-1:0]        fetch_data_i,
    input  logic [$clog2(fetch_parcels_p):0]     fetch_count_i,
    output logic [31:0]                          instr_o,
    output logic [vaddr_width_p-1:0]             instr_pc_o,
    output logic                                 instr_compressed_o,
    output logic                                 instr_v_o,
    input  logic                                 instr_yumi_i,
    output logic                                 partial_v_o
);

    localparam int ptr_w = $clog2(buf_els_p);
    localparam int cnt_w = ptr_w + 1;
    localparam int sum_w = cnt_w + 1;

    logic [15:0]              buf_r [buf_els_p];
    logic [ptr_w-1:0]         head_r, tail_r, head_n_s, tail_n_s;
    logic [cnt_w-1:0]         count_r, count_n_s;
    logic [vaddr_width_p-1:0] head_pc_r, head_pc_n_s;

    logic [15:0]              head_parcel_s, next_parcel_s;
    logic [sum_w-1:0]         space_sum_s;
    logic                     accept_s, deq_s;
    logic [cnt_w-1:0]         add_s, sub_s;
    logic [ptr_w-1:0]         next_idx_s;

    // Head view of the buffer and the derived instruction outputs
    always_comb begin
        next_idx_s         = head_r + ptr_w'(1);
        head_parcel_s      = buf_r[head_r];
        next_parcel_s      = buf_r[next_idx_s];
        instr_compressed_o = (head_parcel_s[1:0] != 2'b11);
        instr_v_o          = ((count_r >= cnt_w'(1)) & instr_compressed_o) | (count_r >= cnt_w'(2));
        partial_v_o        = (count_r == cnt_w'(1)) & ~instr_compressed_o;
        instr_pc_o         = head_pc_r;
        if (instr_compressed_o) begin
            instr_o = {16'h0000, head_parcel_s};
        end else begin
            instr_o = {next_parcel_s, head_parcel_s};
        end
    end

    // Handshake decode; space is judged on the current count only, no dequeue credit
    always_comb begin
        space_sum_s       = sum_w'(count_r) + sum_w'(fetch_count_i);
        fetch_ready_and_o = ~flush_i & (space_sum_s <= sum_w'(buf_els_p));
        accept_s          = fetch_v_i & fetch_ready_and_o;
        deq_s             = instr_yumi_i & instr_v_o & ~flush_i;
        if (accept_s) begin
            add_s = cnt_w'(fetch_count_i);
        end else begin
            add_s = '0;
        end
        if (deq_s) begin
            sub_s = instr_compressed_o ? cnt_w'(1) : cnt_w'(2);
        end else begin
            sub_s = '0;
        end
    end

    // Next-state for pointers, occupancy and head PC; flush clears the queue
    always_comb begin
        head_n_s    = head_r;
        tail_n_s    = tail_r;
        count_n_s   = count_r;
        head_pc_n_s = head_pc_r;
        if (flush_i) begin
            head_n_s  = '0;
            tail_n_s  = '0;
            count_n_s = '0;
        end else begin
            tail_n_s  = tail_r + ptr_w'(add_s);
            head_n_s  = head_r + ptr_w'(sub_s);
            count_n_s = count_r + add_s - sub_s;
            // An empty buffer takes its PC from the incoming block; otherwise the PC is implied
            if (accept_s && (count_r == cnt_w'(0))) begin
                head_pc_n_s = fetch_pc_i;
            end else if (deq_s) begin
                head_pc_n_s = head_pc_r + (instr_compressed_o ? vaddr_width_p'(2) : vaddr_width_p'(4));
            end else begin
                head_pc_n_s = head_pc_r;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r    <= '0;
            tail_r    <= '0;
            count_r   <= '0;
            head_pc_r <= '0;
        end else begin
            head_r    <= head_n_s;
            tail_r    <= tail_n_s;
            count_r   <= count_n_s;
            head_pc_r <= head_pc_n_s;
        end
    end

    // Parcel storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < fetch_parcels_p; i++) begin
            if (accept_s && (cnt_w'(i) < cnt_w'(fetch_count_i))) begin
                buf_r[tail_r + ptr_w'(i)] <= fetch_data_i[16*i +: 16];
            end
        end
    end

endmodule

// File: doc/bp_fe_realigner.md
BP_FE_REALIGNER -- requirements
Module: bp_fe_realigner

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39: virtual PC width.
REQ-002 SHALL have parameter fetch_parcels_p, default 4: 16-bit parcels per fetch block; power of 2, at least 2.
REQ-003 SHALL have parameter buf_els_p, default 8: parcel buffer depth; power of 2, at least 2*fetch_parcels_p.
REQ-004 SHALL have port clk_i, input, 1: clock; one clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset; synchronous, active-high.
REQ-006 SHALL have port flush_i, input, 1: discard all buffered parcels.
REQ-007 SHALL have port fetch_v_i, input, 1: fetch block valid.
REQ-008 SHALL have port fetch_ready_and_o, output, 1: block accepted when high with fetch_v_i.
REQ-009 SHALL have port fetch_pc_i, input, vaddr_width_p: PC of parcel 0; bit 0 is zero.
REQ-010 SHALL have port fetch_data_i, input, 16*fetch_parcels_p: parcels, parcel 0 in the LSBs.
REQ-011 SHALL have port fetch_count_i, input, $clog2(fetch_parcels_p)+1: valid parcels from parcel 0; range 1..fetch_parcels_p.
REQ-012 SHALL have port instr_o, input-side-independent output, 32: head instruction; upper 16 bits zero when compressed.
REQ-013 SHALL have port instr_pc_o, output, vaddr_width_p: PC of the head instruction.
REQ-014 SHALL have port instr_compressed_o, output, 1: head parcel bits[1:0] != 2'b11.
REQ-015 SHALL have port instr_v_o, output, 1: a complete instruction is at the head.
REQ-016 SHALL have port instr_yumi_i, input, 1: consumer takes the head; legal only while instr_v_o is high.
REQ-017 SHALL have port partial_v_o, output, 1: exactly one parcel is buffered and it is the low half of a 32-bit instruction.

Function
REQ-018 SHALL hold parcels in a circular buffer of buf_els_p entries, tracked by a head pointer, a tail pointer and a count; pointers wrap modulo buf_els_p.
REQ-019 SHALL drive fetch_ready_and_o = ~flush_i & (count + fetch_count_i <= buf_els_p), using the current-cycle count only; a same-cycle dequeue SHALL NOT credit space.
REQ-020 SHALL, on acceptance, write parcels 0..fetch_count_i-1 at tail..tail+fetch_count_i-1 and advance tail by fetch_count_i.
REQ-021 SHALL, on acceptance while count==0, load head_pc from fetch_pc_i; while count>0, fetch_pc_i is guaranteed to equal head_pc+2*count, and the block SHALL ignore it.
REQ-022 SHALL drive instr_v_o = (count>=1 & instr_compressed_o) | (count>=2).
REQ-023 SHALL drive partial_v_o = (count==1) & ~instr_compressed_o.
REQ-024 SHALL form instr_o combinationally from buffer[head] (low half) and buffer[head+1 mod buf_els_p] (high half); data is valid only when instr_v_o is high.
REQ-025 SHALL, on instr_yumi_i, advance head and decrement count by 1 if compressed or by 2 otherwise, and add 2 or 4 to head_pc, wrapping modulo 2^vaddr_width_p.
REQ-026 SHALL, on a cycle with simultaneous enqueue and dequeue, update count to count + fetch_count_i - consumed.
REQ-027 SHALL give zero-cycle latency from buffer to output; a parcel accepted in cycle N is visible on instr_o in cycle N+1.
REQ-028 SHALL, when flush_i is high, set count, head and tail to 0 on the next edge; flush_i SHALL win over a same-cycle fetch (not accepted) and over instr_yumi_i (no effect).
REQ-029 SHALL NOT fire instr_v_o for a straddling instruction until its second parcel has been written.

Reset
REQ-030 SHALL, while reset_i is high, set count, head, tail and head_pc to 0; reset SHALL override flush_i, fetch and yumi.
REQ-031 SHALL, after reset, drive instr_v_o=0 and partial_v_o=0; with count 0, fetch_ready_and_o SHALL be 1 unless flush_i is high.
REQ-032 SHALL, when reset_i is asserted mid-stream, discard all buffered parcels, including a pending partial.

Verification
REQ-033 SHALL cover the compressed stream: accept pc=0x1000 with 4 parcels 0x0001 ×4 -> 4 consecutive instructions, pc 0x1000/0x1002/0x1004/0x1006, instr_o=0x00000001.
REQ-034 SHALL cover the straddle: accept pc=0x2000 with count=1 and parcel 0x0013 -> partial_v_o=1, instr_v_o=0; then accept 1 parcel 0x0000 -> instr_o=0x00000013, pc=0x2000.
REQ-035 SHALL cover the full buffer: 8 parcels buffered -> fetch_ready_and_o=0; after one 32-bit yumi, ready returns next cycle; with 2 free, count=2 is accepted and count=3 is refused.
REQ-036 SHALL cover wrap-around: run 20 mixed 16/32-bit instructions with random yumi -> PCs are contiguous and data is exact across the pointer wrap.
REQ-037 SHALL cover flush collision: flush_i together with fetch_v_i and instr_yumi_i at count=5 -> next cycle count=0, instr_v_o=0, and the fetched block is absent.
REQ-038 SHALL cover reset with a pending partial -> partial_v_o=0 next cycle; a new block at pc=0x3000 loads head_pc=0x3000.
